// File: rtl/dac_tx_pkg.sv
// Shared types and helpers for the DAC DDR transmit path: FSM encoding,
// midscale level and offset-binary conversion.
package dac_tx_pkg;

  localparam int unsigned URUN_CNT_W = 16;
  localparam int unsigned MAX_DW     = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_MUTE   = 2'd3
  } dac_state_e;

  // Midscale code (1 << (dw-1)), returned in the widest supported width.
  function automatic logic [MAX_DW-1:0] midscale(input int unsigned dw);
    return MAX_DW'(1) << (dw - 1);
  endfunction

  // Two's complement to offset-binary is a flip of the sign bit.
  function automatic logic [MAX_DW-1:0] offset_bin(input logic [MAX_DW-1:0] x,
                                                   input int unsigned dw,
                                                   input logic twos);
    return twos ? (x ^ midscale(dw)) : x;
  endfunction

endpackage

// File: rtl/dac_oddr_lane.sv
// One DDR output bit, SAME_EDGE style: both inputs captured on the rising
// edge; D1 drives the high phase, D2 the low phase (CE=1, no set/reset).
module dac_oddr_lane (
  input  logic i_clk,
  input  logic i_d1,
  input  logic i_d2,
  output logic o_q
);

  logic r_q1;
  logic r_q2;

  always_ff @(posedge i_clk) begin
    r_q1 <= i_d1;
    r_q2 <= i_d2;
  end

  assign o_q = i_clk ? r_q1 : r_q2;

endmodule

// File: rtl/dac_ddr_tx.sv
// Multi-channel DAC DDR output driver with startup/mute FSM and midscale idle.
// Define DAC_TX_UNDERRUN_CNT_EN to build the underrun pulse and counter.
module dac_ddr_tx
  import dac_tx_pkg::*;
#(
  parameter int unsigned NCH       = 2,
  parameter int unsigned DW        = 14,
  parameter int unsigned DDR_MODE  = 0,
  parameter int unsigned TWOS_COMP = 1,
  parameter int unsigned WARM_CYC  = 16
) (
  input  logic                                  sys_clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic                                  mute,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NCH*((DDR_MODE != 0) ? 2 : 1)*DW-1:0] in_data,
  output logic [1:0]                            state_o,
  output logic                                  underrun,
  output logic [URUN_CNT_W-1:0]                 underrun_cnt,
  output logic [NCH-1:0]                        da_clk,
  output logic [NCH-1:0]                        da_wrt,
  output logic [NCH*DW-1:0]                     da_data
);

  localparam int unsigned SPC    = (DDR_MODE != 0) ? 2 : 1;
  localparam int unsigned NSLOT  = NCH * SPC;
  localparam int unsigned SW     = NSLOT * DW;
  localparam int unsigned WARM_W = 16;
  localparam logic [DW-1:0]     MID       = DW'(midscale(DW));
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_CYC - 1);
  localparam logic              WARM_SKIP = (WARM_CYC == 0);
  localparam logic              TWOS      = (TWOS_COMP != 0);

  dac_state_e        r_state;
  dac_state_e        w_next;
  logic              r_in_ready;
  logic [WARM_W-1:0] r_warm_cnt;
  logic [SW-1:0]     r_stage;
  logic [SW-1:0]     w_conv;
  logic              w_warm_done;
  logic              w_strb_d2;

  // Disable wins over everything, including warmup completion and mute.
  function automatic dac_state_e f_next(input dac_state_e s, input logic en,
                                        input logic mt, input logic done);
    dac_state_e n;
    n = s;
    if (!en) begin
      n = ST_IDLE;
    end else begin
      unique case (s)
        ST_IDLE:   n = WARM_SKIP ? ST_RUN : ST_WARMUP;
        ST_WARMUP: if (done) n = mt ? ST_MUTE : ST_RUN;
        ST_RUN:    if (mt) n = ST_MUTE;
        ST_MUTE:   if (!mt) n = ST_RUN;
      endcase
    end
    return n;
  endfunction

  assign w_warm_done = (r_warm_cnt == WARM_LAST);
  assign w_next      = f_next(r_state, enable, mute, w_warm_done);

  for (genvar k = 0; k < NSLOT; k++) begin : g_conv
    assign w_conv[k*DW +: DW] = DW'(offset_bin(MAX_DW'(in_data[k*DW +: DW]), DW, TWOS));
  end

  // State, ready, warmup counter and the sample stage that feeds the data cells.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_warm_cnt <= '0;
      r_stage    <= {NSLOT{MID}};
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == ST_RUN);
      r_warm_cnt <= (r_state == ST_WARMUP) ? r_warm_cnt + WARM_W'(1) : '0;
      if (r_state != ST_RUN) begin
        r_stage <= {NSLOT{MID}};
      end else if (in_valid) begin
        r_stage <= w_conv;
      end
    end
  end

  assign in_ready = r_in_ready;
  assign state_o  = r_state;

`ifdef DAC_TX_UNDERRUN_CNT_EN
  logic                  r_underrun;
  logic [URUN_CNT_W-1:0] r_urun_cnt;

  // A RUN cycle with no sample offered is an underrun; the count saturates.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_underrun <= 1'b0;
      r_urun_cnt <= '0;
    end else begin
      r_underrun <= (r_state == ST_RUN) && !in_valid;
      if ((r_state == ST_RUN) && !in_valid && (r_urun_cnt != '1)) begin
        r_urun_cnt <= r_urun_cnt + URUN_CNT_W'(1);
      end
    end
  end

  assign underrun     = r_underrun;
  assign underrun_cnt = r_urun_cnt;
`else
  assign underrun     = 1'b0;
  assign underrun_cnt = '0;
`endif

  // Strobes rest low in IDLE and run as a half-cycle-late clock elsewhere.
  assign w_strb_d2 = (r_state != ST_IDLE);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    dac_oddr_lane u_clk (
      .i_clk (sys_clk),
      .i_d1  (1'b0),
      .i_d2  (w_strb_d2),
      .o_q   (da_clk[c])
    );
    dac_oddr_lane u_wrt (
      .i_clk (sys_clk),
      .i_d1  (1'b0),
      .i_d2  (w_strb_d2),
      .o_q   (da_wrt[c])
    );
    for (genvar b = 0; b < DW; b++) begin : g_bit
      dac_oddr_lane u_dat (
        .i_clk (sys_clk),
        .i_d1  (r_stage[(c*SPC)*DW + b]),
        .i_d2  (r_stage[(c*SPC + SPC - 1)*DW + b]),
        .o_q   (da_data[c*DW + b])
      );
    end
  end

endmodule

// File: doc/dac_ddr_tx.md
# dac_ddr_tx

Parametrised multi-channel DAC output driver. Accepts per-clock sample words over a valid/ready stream, converts them to the DAC's offset-binary code, and drives each channel's clock strobe, write strobe and data bus through DDR output cells on `sys_clk`. Adds a startup/mute state machine, a midscale-safe idle level, an optional two-samples-per-clock interleaved mode and underrun accounting. Sits between the NCO/DSP sample path and the DAC pads.

## Interface
- `NCH`, 2: number of DAC channels.
- `DW`, 14: DAC data width per sample.
- `DDR_MODE`, 0: 0 = one sample per clock, repeated on both edges; 1 = two samples per clock, rising edge then falling edge.
- `TWOS_COMP`, 1: 1 = input is two's complement and converted by inverting the MSB; 0 = input already offset-binary.
- `WARM_CYC`, 16: cycles of midscale output with strobes running before `RUN`. Range 0..65535.
- `SPC` (derived, not settable): `DDR_MODE ? 2 : 1`.

Ports:
- `sys_clk` in 1: single clock. Also the DDR cell clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: level. Starts the output; deasserting it returns the block to `IDLE`.
- `mute` in 1: level. Forces midscale while strobes keep running.
- `in_valid` in 1: sample word valid.
- `in_ready` out 1: block accepts the word.
- `in_data` in NCH*SPC*DW: channel c, slot s at bits `[(c*SPC+s)*DW +: DW]`. Slot 0 goes on the rising edge.
- `state_o` out 2: IDLE=0, WARMUP=1, RUN=2, MUTE=3.
- `underrun` out 1: one-cycle pulse for each RUN cycle without a sample.
- `underrun_cnt` out 16: saturating underrun count.
- `da_clk` out NCH: per-channel DDR clock strobe.
- `da_wrt` out NCH: per-channel DDR write strobe.
- `da_data` out NCH*DW: per-channel DDR data buses.

## Operation
- FSM transitions:
  - IDLE→WARMUP when `enable`=1. If `WARM_CYC`=0, go to RUN instead.
  - WARMUP counts `WARM_CYC` cycles, then goes to RUN, or to MUTE if `mute`=1 at that cycle.
  - RUN→MUTE when `mute`=1.
  - MUTE→RUN when `mute`=0.
  - Any state→IDLE when `enable`=0. This has priority over `mute` and over warmup completion.
- Outputs by state:
  - `in_ready` = (state==RUN). It is registered, so it reflects the current state.
  - On a transfer (`in_valid & in_ready`), the converted samples load into the stage register.
  - In RUN with `in_valid`=0, the stage register holds the last sample, `underrun` pulses and `underrun_cnt` increments, saturating at 16'hFFFF.
  - In IDLE, WARMUP and MUTE, the stage register loads MIDSCALE = 1<<(DW-1) in every slot.
  - In IDLE, the strobe cells get D1=D2=0, so `da_clk` and `da_wrt` are held low.
  - In all other states, the strobe cells get D1=0, D2=1.
  - Data cells get D1=slot0 and D2=(SPC==2 ? slot1 : slot0).
- Conversion: offset = TWOS_COMP ? {~x[DW-1], x[DW-2:0]} : x. No saturation is needed.
- Reset (mid-operation included) sets:
  - state=IDLE, `in_ready`=0, `underrun`=0, `underrun_cnt`=0;
  - stage register=MIDSCALE, warmup counter=0;
  - `da_clk`, `da_wrt` low and `da_data`=MIDSCALE one cycle after the reset edge.

## Timing
- Sample transfer at edge N → stage register at N → DDR cells capture at N+1. Rising-edge data is visible after N+1; falling-edge data half a cycle later. Total latency is 2 edges.
- A state change at edge N affects DDR cell inputs at N. The pins follow at N+1.
- WARMUP lasts exactly `WARM_CYC` cycles, counted from the first WARMUP cycle.
- `underrun` is registered and asserts in the cycle after the missed RUN cycle.
- MUTE entry: midscale reaches the pins 2 edges after the `mute` sample edge. Data accepted before that still drains normally.

## Configuration
- `DAC_TX_UNDERRUN_CNT_EN` defined: the `underrun` pulse and 16-bit `underrun_cnt` logic are compiled in.
- Not defined: `underrun` is tied 0, `underrun_cnt` is tied 0, and no counter logic is built. Hold-last-sample behaviour on underrun is unchanged.

## Structure
- Package `dac_tx_pkg`:
  - state enum (IDLE/WARMUP/RUN/MUTE) with the encodings above;
  - `midscale(DW)` function;
  - `offset_bin` conversion function;
  - underrun counter width constant (16).
- Sub-module `dac_oddr_lane`: one DDR output bit wrapping the device ODDR cell (SAME_EDGE, CE=1, R=S=0). It is instantiated per strobe and per data bit through generate loops.

## Test plan
- `rst` → `da_clk`/`da_wrt`=0 and `da_data`=14'h2000 on both channels; state IDLE; `in_ready`=0.
- `enable`=1, `WARM_CYC`=16 → 16 cycles of state WARMUP with strobes toggling and data 14'h2000, then RUN and `in_ready`=1.
- RUN, TWOS_COMP=1, in 14'h0000, 14'h2000, 14'h1FFF → pins 14'h2000, 14'h0000, 14'h3FFF, each 2 edges after transfer.
- DDR_MODE=1, ch0 slots {0x0100, 0x0200} → rising edge 0x2100, falling edge 0x2200.
- RUN with `in_valid` low for 3 cycles → data holds last value; `underrun_cnt` 0→3; 3 `underrun` pulses. With macro undefined → both stay 0.
- In RUN assert `mute`, then drop `enable` together with `mute` → MUTE (midscale, `in_ready`=0), then IDLE with strobes low. Assert `rst` mid-RUN → full reset values on the next cycle.
